ant_move_arbiter: RTL and testbench

Round-robin arbiter that shares a single maze-engine move port among `N_ANT` ant controllers. Each ant posts a move request. The arbiter grants one ant at a time, drives the move to the engine, and waits for the engine's completion. Engine feedback is routed back per ant: a hit starts a backoff period for that ant, and an escape retires it.

---
 rtl/ant_move_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ant_move_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_move_arbiter.sv
// ant_move_arbiter
//
// Round-robin arbiter sharing one maze-engine move port among N_ANT ant
// controllers. One ant is granted at a time, its move is presented to the
// engine, and the engine's completion is routed back to that ant. A move
// that hits a wall puts the ant into a HIT_BACKOFF-cycle backoff. An escape
// retires the ant until reset. A HALT move bypasses the engine.
//
// Optional feature macro: ANT_WATCHDOG_EN adds an engine timeout of
// WD_CYCLES EXEC cycles and the sticky wd_err output.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-ant move request
//   move_in      per-ant 2-bit move, ant i on bits [2i+1:2i]
//   grant        one-hot, one-cycle completion pulse
//   exec_valid   move presented to the engine
//   exec_ant     index of the presented ant
//   exec_move    presented move
//   exec_done    engine completion (only looked at in EXEC)
//   hit          completed move hit a wall (qualified by exec_done)
//   escape       ant left the maze (qualified by exec_done)
//   retired      sticky per-ant escaped flags
//   all_escaped  every ant retired
//   wd_err       sticky engine timeout (ANT_WATCHDOG_EN only)
//
// State | meaning
//   S_IDLE | pick next eligible ant at or above rr
//   S_EXEC | move presented to engine, waiting for exec_done
//   S_ACK  | grant pulse for exec_ant, advance rr

`ifndef ANT_MOVE_HALT
`define ANT_MOVE_HALT    2'b00
`define ANT_MOVE_RIGHT   2'b01
`define ANT_MOVE_LEFT    2'b10
`define ANT_MOVE_FORWARD 2'b11
`endif

module ant_move_arbiter #(
    parameter int N_ANT       = 4,
    parameter int AW          = 2,
    parameter int HIT_BACKOFF = 3,
    parameter int WD_CYCLES   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ANT-1:0]   req,
    input  logic [2*N_ANT-1:0] move_in,
    output logic [N_ANT-1:0]   grant,
    output logic               exec_valid,
    output logic [AW-1:0]      exec_ant,
    output logic [1:0]         exec_move,
    input  logic               exec_done,
    input  logic               hit,
    input  logic               escape,
    output logic [N_ANT-1:0]   retired,
    output logic               all_escaped
`ifdef ANT_WATCHDOG_EN
    ,
    output logic               wd_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK} state_t;

    state_t           state;
    logic [AW-1:0]    rr;
    logic [3:0]       boff_cnt [N_ANT];
    logic [N_ANT-1:0] elig;
    logic             sel_found;
    logic [AW-1:0]    sel_idx;
    logic [1:0]       sel_move;
    logic [N_ANT-1:0] sel_onehot;
    logic [N_ANT-1:0] ant_onehot;
    logic [N_ANT-1:0] retired_nxt;

`ifdef ANT_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;
`else
    logic unused_wd_cfg;
    assign unused_wd_cfg = (WD_CYCLES > 0);
`endif

    always_comb begin
        for (int i = 0; i < N_ANT; i++) begin
            elig[i] = req[i] && !retired[i] && (boff_cnt[i] == 4'd0);
        end
    end

    // Lowest eligible ant overall is the wrap-around fallback; the second
    // pass overrides it with the lowest eligible ant at or above rr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_ANT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
            end
        end
        for (int i = N_ANT - 1; i >= 0; i--) begin
            if (elig[i] && (AW'(i) >= rr)) begin
                sel_idx = AW'(i);
            end
        end
    end

    always_comb begin
        sel_move            = move_in[{sel_idx, 1'b0} +: 2];
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
        ant_onehot           = '0;
        ant_onehot[exec_ant] = 1'b1;
    end

    always_comb begin
        retired_nxt = retired;
        if (state == S_EXEC && exec_done && escape) begin
            retired_nxt[exec_ant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr          <= '0;
            grant       <= '0;
            exec_valid  <= 1'b0;
            exec_ant    <= '0;
            exec_move   <= `ANT_MOVE_HALT;
            retired     <= '0;
            all_escaped <= 1'b0;
            for (int i = 0; i < N_ANT; i++) begin
                boff_cnt[i] <= 4'd0;
            end
`ifdef ANT_WATCHDOG_EN
            wd_cnt <= '0;
            wd_err <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < N_ANT; i++) begin
                if (boff_cnt[i] != 4'd0) begin
                    boff_cnt[i] <= boff_cnt[i] - 4'd1;
                end
            end
            retired     <= retired_nxt;
            all_escaped <= &retired_nxt;

            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        exec_ant  <= sel_idx;
                        exec_move <= sel_move;
                        if (sel_move == `ANT_MOVE_HALT) begin
                            grant <= sel_onehot;
                            state <= S_ACK;
                        end else begin
                            exec_valid <= 1'b1;
                            state      <= S_EXEC;
`ifdef ANT_WATCHDOG_EN
                            wd_cnt <= '0;
`endif
                        end
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        exec_valid <= 1'b0;
                        grant      <= ant_onehot;
                        state      <= S_ACK;
                        // Overrides this cycle's decrement of the same counter.
                        if (hit) begin
                            boff_cnt[exec_ant] <= 4'(HIT_BACKOFF);
                        end
                    end
`ifdef ANT_WATCHDOG_EN
                    else if (wd_cnt == WDW'(WD_CYCLES - 1)) begin
                        wd_err     <= 1'b1;
                        exec_valid <= 1'b0;
                        grant      <= ant_onehot;
                        state      <= S_ACK;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_ACK: begin
                    grant <= '0;
                    rr    <= (exec_ant == AW'(N_ANT - 1)) ? '0 : exec_ant + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ant_move_arbiter.sv
// Testbench for ant_move_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the arbiter rules.

`ifndef ANT_MOVE_HALT
`define ANT_MOVE_HALT    2'b00
`define ANT_MOVE_RIGHT   2'b01
`define ANT_MOVE_LEFT    2'b10
`define ANT_MOVE_FORWARD 2'b11
`endif

module tb_ant_move_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int HB = 3;
    localparam int WD = 16;

    localparam logic [1:0] MV_HALT = `ANT_MOVE_HALT;
    localparam logic [1:0] MV_LEFT = `ANT_MOVE_LEFT;
    localparam logic [1:0] MV_FWD  = `ANT_MOVE_FORWARD;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [2*N-1:0] move_in;
    logic [N-1:0]   grant;
    logic           exec_valid;
    logic [AW-1:0]  exec_ant;
    logic [1:0]     exec_move;
    logic           exec_done;
    logic           hit;
    logic           escape;
    logic [N-1:0]   retired;
    logic           all_escaped;
`ifdef ANT_WATCHDOG_EN
    logic           wd_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ant_move_arbiter #(
        .N_ANT(N), .AW(AW), .HIT_BACKOFF(HB), .WD_CYCLES(WD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .move_in(move_in),
        .grant(grant),
        .exec_valid(exec_valid),
        .exec_ant(exec_ant),
        .exec_move(exec_move),
        .exec_done(exec_done),
        .hit(hit),
        .escape(escape),
        .retired(retired),
        .all_escaped(all_escaped)
`ifdef ANT_WATCHDOG_EN
        ,
        .wd_err(wd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = choosing, 1 = engine busy, 2 = acknowledging
    int            m_phase;
    int            m_rr;
    int            m_boff [N];
    int            m_wd;
    logic [N-1:0]  m_ret;
    logic [N-1:0]  m_grant;
    logic          m_valid;
    logic          m_all;
    logic          m_wd_err;
    logic [AW-1:0] m_ant;
    logic [1:0]    m_move;

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_wd = 0;
        for (int i = 0; i < N; i++) m_boff[i] = 0;
        m_ret = '0; m_grant = '0; m_valid = 1'b0; m_all = 1'b0;
        m_wd_err = 1'b0; m_ant = '0; m_move = MV_HALT;
    endtask

    task automatic model_step();
        int sel;
        int a;
        sel = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                a = (m_rr + k) % N;
                if (sel < 0 && req[a] && !m_ret[a] && m_boff[a] == 0) sel = a;
            end
        end
        for (int i = 0; i < N; i++) if (m_boff[i] > 0) m_boff[i] = m_boff[i] - 1;
        case (m_phase)
            0: if (sel >= 0) begin
                m_ant  = AW'(sel);
                m_move = move_in[2*sel +: 2];
                if (m_move == MV_HALT) begin
                    m_grant = '0; m_grant[sel] = 1'b1; m_phase = 2;
                end else begin
                    m_valid = 1'b1; m_phase = 1; m_wd = 0;
                end
            end
            1: begin
                if (exec_done) begin
                    m_valid = 1'b0; m_grant = '0; m_grant[m_ant] = 1'b1; m_phase = 2;
                    if (hit) m_boff[m_ant] = HB;
                    if (escape) m_ret[m_ant] = 1'b1;
                end
`ifdef ANT_WATCHDOG_EN
                else if (m_wd == WD - 1) begin
                    m_wd_err = 1'b1; m_valid = 1'b0;
                    m_grant = '0; m_grant[m_ant] = 1'b1; m_phase = 2;
                end else begin
                    m_wd = m_wd + 1;
                end
`endif
            end
            default: begin
                m_grant = '0;
                m_rr    = (int'(m_ant) + 1) % N;
                m_phase = 0;
            end
        endcase
        m_all = &m_ret;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("grant",       32'(grant),       32'(m_grant));
        check_eq("exec_valid",  32'(exec_valid),  32'(m_valid));
        check_eq("exec_ant",    32'(exec_ant),    32'(m_ant));
        check_eq("exec_move",   32'(exec_move),   32'(m_move));
        check_eq("retired",     32'(retired),     32'(m_ret));
        check_eq("all_escaped", 32'(all_escaped), 32'(m_all));
`ifdef ANT_WATCHDOG_EN
        check_eq("wd_err",      32'(wd_err),      32'(m_wd_err));
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; move_in = '0;
        exec_done = 1'b0; hit = 1'b0; escape = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (!exec_valid && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(exec_valid), 32'd1);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (!req[i] || m_grant[i]) begin
                req[i]           = ($urandom_range(0, 2) != 0);
                move_in[2*i +: 2] = 2'($urandom_range(0, 3));
            end
        end
        exec_done = ($urandom_range(0, 2) == 0);
        hit       = ($urandom_range(0, 3) == 0);
        escape    = ($urandom_range(0, 24) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int seq [$];
        int gseq [$];
        logic prev_v;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        logic saw;

        rst_n = 1'b0; req = '0; move_in = '0;
        exec_done = 1'b0; hit = 1'b0; escape = 1'b0;
        tick();
        tick();
        check_eq("rst_exec_valid", 32'(exec_valid), 32'd0);
        check_eq("rst_grant",      32'(grant),      32'd0);
        check_eq("rst_exec_move",  32'(exec_move),  32'(MV_HALT));
        check_eq("rst_retired",    32'(retired),    32'd0);
        rst_n = 1'b1;

        // round-robin order with all ants requesting FORWARD
        req = 4'b1111; move_in = {4{MV_FWD}}; exec_done = 1'b1;
        prev_v = 1'b0;
        repeat (16) begin
            tick();
            if (exec_valid && !prev_v) seq.push_back(int'(exec_ant));
            prev_v = exec_valid;
            if (grant != '0) gseq.push_back(onehot_idx(grant));
        end
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("rr_seq%0d", k), 32'((k < seq.size()) ? seq[k] : 99), 32'(exp_seq[k]));
            check_eq($sformatf("rr_grant%0d", k), 32'((k < gseq.size()) ? gseq[k] : 99), 32'(exp_seq[k]));
        end

        // hit backoff on ant 2
        do_reset();
        req = 4'b0100; move_in = 8'h00; move_in[5:4] = MV_LEFT;
        wait_valid("hit_select", 10, n);
        exec_done = 1'b1; hit = 1'b1;
        tick();
        check_eq("hit_grant", 32'(grant), 32'h4);
        exec_done = 1'b0; hit = 1'b0;
        n = 1;
        while (!exec_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("hit_reselect_delay", 32'(n), 32'd5);

        // escape of ant 1, then it is never selected again
        do_reset();
        req = 4'b0010; move_in = {4{MV_FWD}}; exec_done = 1'b1; escape = 1'b1;
        repeat (3) tick();
        check_eq("esc_retired", 32'(retired), 32'h2);
        escape = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (exec_valid) saw = 1'b1;
        end
        check_eq("esc_never_again", 32'(saw), 32'd0);

        // reset in the middle of EXEC
        exec_done = 1'b0; req = 4'b0101;
        wait_valid("mid_rst_exec", 10, n);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid",   32'(exec_valid), 32'd0);
        check_eq("mid_rst_grant",   32'(grant),      32'd0);
        check_eq("mid_rst_retired", 32'(retired),    32'd0);
        tick();
        rst_n = 1'b1;
        wait_valid("post_rst_exec", 10, n);
        check_eq("post_rst_ant", 32'(exec_ant), 32'd0);
        exec_done = 1'b1;
        tick();
        check_eq("post_rst_grant", 32'(grant), 32'h1);

        // every ant escapes
        do_reset();
        req = 4'b1111; move_in = {4{MV_FWD}}; exec_done = 1'b1; escape = 1'b1;
        repeat (14) tick();
        check_eq("all_retired", 32'(retired),     32'hF);
        check_eq("all_escaped", 32'(all_escaped), 32'd1);

        // HALT bypasses the engine, one grant every 2 cycles
        do_reset();
        req = 4'b0001; move_in = {4{MV_HALT}};
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("halt_grant%0d", k), 32'(grant), 32'((k % 2 == 0) ? 1 : 0));
            check_eq($sformatf("halt_valid%0d", k), 32'(exec_valid), 32'd0);
        end

`ifdef ANT_WATCHDOG_EN
        // engine never answers
        do_reset();
        req = 4'b0001; move_in = {4{MV_FWD}}; exec_done = 1'b0;
        wait_valid("wd_select", 10, n);
        n = 0;
        while (grant == '0 && n < 40) begin
            if (exec_valid) n++;
            tick();
        end
        check_eq("wd_exec_cycles", 32'(n), 32'(WD));
        check_eq("wd_err_set",     32'(wd_err), 32'd1);
        check_eq("wd_grant",       32'(grant),  32'h1);
        wait_valid("wd_continue", 10, n);
        exec_done = 1'b1;
        tick();
`endif

        // randomized traffic
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                tick();
                drive_random();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
